// File: rtl/cpu_defs.sv
// Shared encodings for the multi-cycle CPU: opcodes, controller states,
// datapath mux selects and the control word driven into the datapath.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_MWB   = 4'd4,
    S_MWR   = 4'd5,
    S_REXE  = 4'd6,
    S_RWB   = 4'd7,
    S_BEQ   = 4'd8,
    S_JMP   = 4'd9,
    S_IEXE  = 4'd10,
    S_IWB   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Moore decode: maps the controller state onto the datapath control word.
// Unlisted fields and unused state codes decode to all zeros.
module ctrl_decode
  import cpu_defs::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_ID: begin
        ctrl.alu_src_b = SRCB_BOFF;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MADDR, S_IEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_REXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_OUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: state register, opcode-driven sequencing
// and reset gating of the Moore-decoded control word.
module multicycle_ctrl
  import cpu_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  logic   illegal;
  ctrl_t  ctrl;
  ctrl_t  ctrl_g;

  // Branches resolve in the datapath via pc_write_cond & zero.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    illegal = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MADDR;
          OP_RTYPE:     state_d = S_REXE;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
          OP_ADDI:      state_d = S_IEXE;
          default: begin
            state_d = S_IF;
            illegal = 1'b1;
          end
        endcase
      end
      S_MADDR: state_d = (op == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   state_d = S_MWB;
      S_REXE:  state_d = S_RWB;
      S_IEXE:  state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign ctrl_g = rst ? '0 : ctrl;

  assign pc_write      = ctrl_g.pc_write;
  assign pc_write_cond = ctrl_g.pc_write_cond;
  assign iord          = ctrl_g.iord;
  assign mem_read      = ctrl_g.mem_read;
  assign mem_write     = ctrl_g.mem_write;
  assign ir_write      = ctrl_g.ir_write;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign reg_dst       = ctrl_g.reg_dst;
  assign reg_write     = ctrl_g.reg_write;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign alu_op        = ctrl_g.alu_op;
  assign pc_source     = ctrl_g.pc_source;
  assign instr_done    = ctrl_g.instr_done;
  assign illegal_op    = illegal & ~rst;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected state and
// control vectors are queued per instruction and compared mid-cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          st;
    logic [17:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .op            (op),
    .zero          (zero),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  function automatic logic [17:0] obs_vec();
    return {pc_write, pc_write_cond, iord, mem_read, mem_write,
            ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
            alu_src_b, alu_op, pc_source, instr_done, illegal_op};
  endfunction

  // Expected outputs written straight from the state table.
  function automatic logic [17:0] exp_vec(int s, bit ill);
    logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, dn, il;
    logic [1:0] asb, aop, pcs;
    {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, dn, il} = '0;
    {asb, aop, pcs} = '0;
    case (s)
      0:  begin mr = 1; irw = 1; asb = 2'b01; pw = 1; end
      1:  begin asb = 2'b11; il = ill; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; io = 1; dn = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; dn = 1; end
      9:  begin pw = 1; pcs = 2'b10; dn = 1; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; dn = 1; end
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa,
            asb, aop, pcs, dn, il};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_instr(input logic [5:0] o);
    int seq[$];
    bit ill = 0;
    case (o)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 9};
      6'b001000: seq = '{0, 1, 10, 11};
      default: begin seq = '{0, 1}; ill = 1; end
    endcase
    foreach (seq[i]) sb.push_back('{seq[i], exp_vec(seq[i], ill)});
  endtask

  // Entered just after a rising edge with the DUT in IF.
  task automatic run_instr(input string name, input logic [5:0] o,
                           input int exp_cycles, input int exp_done);
    int cyc = 0;
    int dones = 0;
    exp_t e;
    op = o;
    push_instr(o);
    while (sb.size() > 0 && cyc < 8) begin
      @(negedge clk);
      zero = 1'($urandom);
      e = sb.pop_front();
      check({name, "_state"}, 32'(state), 32'(e.st));
      check({name, "_ctrl"}, 32'(obs_vec()), 32'(e.v));
      if (mem_read && mem_write) check("mr_mw_excl", 1, 0);
      if (pc_write && pc_write_cond) check("pw_pwc_excl", 1, 0);
      dones += int'(instr_done);
      if (instr_done) check({name, "_done_cyc"}, cyc + 1, exp_cycles);
      cyc++;
      @(posedge clk);
      #1;
    end
    check({name, "_cycles"}, cyc, exp_cycles);
    check({name, "_dones"}, dones, exp_done);
    sb.delete();
  endtask

  initial begin
    logic [5:0] ops[6];
    int cyc_tab[6];
    ops     = '{6'b100011, 6'b101011, 6'b000000,
                6'b000100, 6'b000010, 6'b001000};
    cyc_tab = '{5, 4, 4, 3, 3, 4};
    rst  = 1'b1;
    op   = 6'b111111;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_ctrl", 32'(obs_vec()), 0);
    rst = 1'b0;
    #1;
    check("rel_ctrl", 32'(obs_vec()), 32'(exp_vec(0, 0)));

    run_instr("lw", 6'b100011, 5, 1);
    run_instr("r", 6'b000000, 4, 1);
    run_instr("sw", 6'b101011, 4, 1);
    run_instr("beq", 6'b000100, 3, 1);
    run_instr("j", 6'b000010, 3, 1);
    run_instr("addi", 6'b001000, 4, 1);
    run_instr("ill", 6'b111111, 2, 0);
    run_instr("ill2", 6'b010101, 2, 0);
    for (int k = 0; k < 8; k++) begin
      int idx = $urandom_range(0, 5);
      run_instr("rnd", ops[idx], cyc_tab[idx], 1);
    end

    // Abort a load in MRD.
    op = 6'b100011;
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_state", 32'(state), 3);
    check("abort_pre_mr", 32'(mem_read), 1);
    rst = 1'b1;
    #1;
    check("abort_mr_drop", 32'(mem_read), 0);
    check("abort_ctrl", 32'(obs_vec()), 0);
    @(posedge clk);
    #1;
    check("abort_state", 32'(state), 0);
    check("abort_rw", 32'(reg_write), 0);
    rst = 1'b0;
    #1;
    run_instr("post_lw", 6'b100011, 5, 1);
    run_instr("post_addi", 6'b001000, 4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
